reg_file_cmd_ctrl: RTL and testbench
====================================

Name: reg_file_cmd_ctrl

Overview:
Command front-end sitting directly upstream of the register file. It parses a byte stream from the UART receive path into write and read frames, then drives the register file's WrEn/RdEn/Address/WrData. Read results are returned as two bytes on a valid/busy transmit handshake. Single clock domain, registered outputs throughout.

Parameters:
ADDR_WIDTH, 3, register file address width; legal addresses are 0 to 2**ADDR_WIDTH-1.
REG_WIDTH, 16, register data width; fixed at 16 and sent/received as two bytes, low byte first.
WR_CMD, 8'hAA, opcode byte that starts a write frame.
RD_CMD, 8'hBB, opcode byte that starts a read frame.
TIMEOUT_CYCLES, 255, inter-byte timeout; used only when CMD_TIMEOUT_EN is defined.

Ports:
CLK  in  1  system clock; all logic on the rising edge.
RST  in  1  synchronous, active-high reset.
RX_P_DATA  in  8  received byte.
RX_D_VLD  in  1  single-cycle strobe; RX_P_DATA is valid in that cycle.
WrEn  out  1  register file write enable; one-cycle pulse.
RdEn  out  1  register file read enable; one-cycle pulse.
Address  out  ADDR_WIDTH  register file address.
WrData  out  REG_WIDTH  register file write data.
RdData  in  REG_WIDTH  register file read data; valid exactly 1 cycle after RdEn.
TX_P_DATA  out  8  byte to transmit.
TX_D_VLD  out  1  transmit request; held high until accepted.
TX_BUSY  in  1  transmitter busy; a byte is accepted at an edge where TX_D_VLD=1 and TX_BUSY=0.
CMD_ERR  out  1  one-cycle error pulse.
CTRL_BUSY  out  1  high in every state except IDLE.

Behaviour:
- Reset: RST=1 at a rising edge forces state to IDLE and clears WrEn, RdEn, Address, WrData, TX_P_DATA, TX_D_VLD, CMD_ERR and CTRL_BUSY to 0. This applies mid-frame and mid-transmit alike; any partial frame is discarded.
- Write frame is 4 bytes: WR_CMD, addr, data_lo, data_hi.
- Read frame is 2 bytes: RD_CMD, addr. It returns rd_lo then rd_hi.
- FSM states: IDLE, WR_ADDR, WR_LO, WR_HI, WR_EXEC, RD_ADDR, RD_EXEC, RD_WAIT, TX_LO, TX_HI.
- IDLE:
  - On RX_D_VLD with WR_CMD, go to WR_ADDR.
  - On RX_D_VLD with RD_CMD, go to RD_ADDR.
  - Any other byte: CMD_ERR pulse, stay in IDLE.
- Address byte:
  - If bits [7:ADDR_WIDTH] are nonzero: CMD_ERR pulse, go to IDLE, no register file access.
  - Otherwise latch bits [ADDR_WIDTH-1:0] into Address.
- Write path:
  - WR_LO latches WrData[7:0]; WR_HI latches WrData[15:8].
  - WR_EXEC: WrEn=1 for exactly one cycle, then IDLE.
  - Latency: WrEn rises the cycle after the data_hi strobe.
- Read path:
  - RD_EXEC: RdEn=1 for one cycle.
  - RD_WAIT: capture RdData into an internal 16-bit holding register.
  - TX_LO: TX_P_DATA = hold[7:0], TX_D_VLD=1 until accepted.
  - TX_HI: same with hold[15:8]; on acceptance go to IDLE.
  - Latency: TX_D_VLD rises 3 cycles after the addr strobe.
- Handshake rules:
  - TX_P_DATA must stay stable while TX_D_VLD=1.
  - TX_D_VLD drops in the cycle after acceptance, except TX_LO→TX_HI, where it stays high with the new byte.
- Idle values:
  - Address and WrData hold their last values between frames.
  - WrEn and RdEn are never high together, and never high outside WR_EXEC/RD_EXEC.
- RX_D_VLD in WR_EXEC, RD_EXEC, RD_WAIT, TX_LO or TX_HI: the byte is dropped, CMD_ERR pulses, and the state is unaffected.
- Opcode bytes inside a frame (e.g. 8'hAA as data) are treated as data; there is no resynchronisation.

Optional Feature:
CMD_TIMEOUT_EN:
- Defined: an inter-byte counter resets on every RX_D_VLD. If the counter reaches TIMEOUT_CYCLES while in WR_ADDR, WR_LO, WR_HI or RD_ADDR, CMD_ERR pulses, the state returns to IDLE and no register file access occurs. The counter is disabled in IDLE and in the execute/transmit states.
- Undefined: no counter is built, and the FSM waits indefinitely for the next frame byte.

Test Plan:
- Reset then idle: RST=1 for 2 cycles -> all outputs 0, CTRL_BUSY=0.
- Write: bytes AA,01,0F,00 -> one WrEn pulse with Address=1, WrData=16'h000F, cycle after the last strobe.
- Read-back: bytes BB,01 with RdData=16'h000F after RdEn -> TX bytes 0F then 00. With TX_BUSY=1 for 5 cycles, TX_D_VLD and TX_P_DATA are held stable.
- Bad address: AA,14,64,00 -> CMD_ERR on the 14 strobe, no WrEn. The following 64 is an unknown opcode and gives CMD_ERR. The following 00 also gives CMD_ERR.
- Reset mid-frame: AA,03,then RST -> IDLE. Then BB,03 -> RdEn with Address=3 and no WrEn ever seen.
- With CMD_TIMEOUT_EN and TIMEOUT_CYCLES=10: AA,02 then no bytes for 10 cycles -> CMD_ERR, CTRL_BUSY=0, no WrEn.

Source files
------------

// File: rtl/reg_file_cmd_ctrl.sv
// reg_file_cmd_ctrl
// Command front-end for the register file. It parses the UART receive byte
// stream into write frames (WR_CMD, addr, data_lo, data_hi) and read frames
// (RD_CMD, addr). It drives the register file strobes, and returns read data
// as two bytes (low byte first) on a valid/busy transmit handshake.
//
// Ports:
//   CLK, RST            clock; synchronous active-high reset
//   RX_P_DATA/RX_D_VLD  received byte and its one-cycle strobe
//   WrEn/RdEn           one-cycle register file strobes
//   Address/WrData      register file address and write data (held between frames)
//   RdData              register file read data, valid one cycle after RdEn
//   TX_P_DATA/TX_D_VLD  byte to transmit; valid is held until accepted
//   TX_BUSY             transmitter busy; a byte is accepted when valid & !busy
//   CMD_ERR             one-cycle error pulse (bad opcode, bad address,
//                       unexpected byte, or timeout)
//   CTRL_BUSY           high whenever the FSM is not in IDLE
//
// Optional feature macro: CMD_TIMEOUT_EN. When it is defined, an inter-byte
// timeout aborts a partial frame after TIMEOUT_CYCLES silent cycles.
module reg_file_cmd_ctrl #(
    parameter int         ADDR_WIDTH     = 3,
    parameter int         REG_WIDTH      = 16,
    parameter logic [7:0] WR_CMD         = 8'hAA,
    parameter logic [7:0] RD_CMD         = 8'hBB,
    parameter int         TIMEOUT_CYCLES = 255
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [7:0]            RX_P_DATA,
    input  logic                  RX_D_VLD,
    output logic                  WrEn,
    output logic                  RdEn,
    output logic [ADDR_WIDTH-1:0] Address,
    output logic [REG_WIDTH-1:0]  WrData,
    input  logic [REG_WIDTH-1:0]  RdData,
    output logic [7:0]            TX_P_DATA,
    output logic                  TX_D_VLD,
    input  logic                  TX_BUSY,
    output logic                  CMD_ERR,
    output logic                  CTRL_BUSY
);

    typedef enum logic [3:0] {
        IDLE, WR_ADDR, WR_LO, WR_HI, WR_EXEC,
        RD_ADDR, RD_EXEC, RD_WAIT, TX_LO, TX_HI
    } state_t;

    state_t               state;
    logic [REG_WIDTH-1:0] hold;
    logic                 addr_ok;
    logic                 tx_accept;
    logic                 tmo_hit;

    // Address bytes with any bit set above the register file range are rejected.
    assign addr_ok   = (RX_P_DATA[7:ADDR_WIDTH] == '0);
    assign tx_accept = TX_D_VLD && !TX_BUSY;

`ifdef CMD_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tmo_cnt;
    logic          waiting;

    // The counter runs only while a frame is waiting for its next byte.
    // The last silent cycle before reaching TIMEOUT_CYCLES fires the abort.
    assign waiting = (state == WR_ADDR) || (state == WR_LO) ||
                     (state == WR_HI)   || (state == RD_ADDR);
    assign tmo_hit = waiting && !RX_D_VLD && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge CLK) begin
        if (RST || !waiting || RX_D_VLD || tmo_hit) tmo_cnt <= '0;
        else                                        tmo_cnt <= tmo_cnt + 1'b1;
    end
`else
    // No timeout in this build: a partial frame waits indefinitely.
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
    assign tmo_hit = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            WrEn      <= 1'b0;
            RdEn      <= 1'b0;
            Address   <= '0;
            WrData    <= '0;
            hold      <= '0;
            TX_P_DATA <= '0;
            TX_D_VLD  <= 1'b0;
            CMD_ERR   <= 1'b0;
            CTRL_BUSY <= 1'b0;
        end else begin
            // These three outputs are pulses, so they default low every cycle.
            WrEn    <= 1'b0;
            RdEn    <= 1'b0;
            CMD_ERR <= 1'b0;

            case (state)
                IDLE: if (RX_D_VLD) begin
                    if (RX_P_DATA == WR_CMD) begin
                        state <= WR_ADDR;  CTRL_BUSY <= 1'b1;
                    end else if (RX_P_DATA == RD_CMD) begin
                        state <= RD_ADDR;  CTRL_BUSY <= 1'b1;
                    end else begin
                        CMD_ERR <= 1'b1;
                    end
                end
                WR_ADDR: if (RX_D_VLD) begin
                    if (addr_ok) begin
                        Address <= RX_P_DATA[ADDR_WIDTH-1:0];
                        state   <= WR_LO;
                    end else begin
                        CMD_ERR <= 1'b1;  state <= IDLE;  CTRL_BUSY <= 1'b0;
                    end
                end
                WR_LO: if (RX_D_VLD) begin
                    WrData[7:0] <= RX_P_DATA;
                    state       <= WR_HI;
                end
                WR_HI: if (RX_D_VLD) begin
                    // WrEn is raised on entry so it is high exactly during WR_EXEC.
                    WrData[15:8] <= RX_P_DATA;
                    WrEn         <= 1'b1;
                    state        <= WR_EXEC;
                end
                WR_EXEC: begin
                    if (RX_D_VLD) CMD_ERR <= 1'b1;
                    state <= IDLE;  CTRL_BUSY <= 1'b0;
                end
                RD_ADDR: if (RX_D_VLD) begin
                    if (addr_ok) begin
                        Address <= RX_P_DATA[ADDR_WIDTH-1:0];
                        RdEn    <= 1'b1;
                        state   <= RD_EXEC;
                    end else begin
                        CMD_ERR <= 1'b1;  state <= IDLE;  CTRL_BUSY <= 1'b0;
                    end
                end
                RD_EXEC: begin
                    if (RX_D_VLD) CMD_ERR <= 1'b1;
                    state <= RD_WAIT;
                end
                RD_WAIT: begin
                    // RdData is valid in this cycle. The low byte is presented
                    // straight away, so TX_D_VLD is already high on entry to TX_LO.
                    if (RX_D_VLD) CMD_ERR <= 1'b1;
                    hold      <= RdData;
                    TX_P_DATA <= RdData[7:0];
                    TX_D_VLD  <= 1'b1;
                    state     <= TX_LO;
                end
                TX_LO: begin
                    if (RX_D_VLD) CMD_ERR <= 1'b1;
                    if (tx_accept) begin
                        TX_P_DATA <= hold[15:8];
                        state     <= TX_HI;
                    end
                end
                TX_HI: begin
                    if (RX_D_VLD) CMD_ERR <= 1'b1;
                    if (tx_accept) begin
                        TX_D_VLD <= 1'b0;
                        state    <= IDLE;  CTRL_BUSY <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;  CTRL_BUSY <= 1'b0;  TX_D_VLD <= 1'b0;
                end
            endcase

            // A timeout can only fire in a waiting state with no byte arriving,
            // so it never competes with a case-branch transition above.
            if (tmo_hit) begin
                CMD_ERR <= 1'b1;  state <= IDLE;  CTRL_BUSY <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_reg_file_cmd_ctrl.sv
// Scoreboard bench for reg_file_cmd_ctrl. Stimulus pushes hand-computed
// expectations into per-kind queues. A negedge monitor pops and compares
// them whenever the DUT pulses WrEn, RdEn or CMD_ERR, or hands over a TX byte.
module tb_reg_file_cmd_ctrl;

    localparam int AW = 3;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic [7:0]    RX_P_DATA = 8'h00;
    logic          RX_D_VLD = 1'b0;
    logic          WrEn, RdEn;
    logic [AW-1:0] Address;
    logic [15:0]   WrData;
    logic [15:0]   RdData = 16'hDEAD;
    logic [7:0]    TX_P_DATA;
    logic          TX_D_VLD;
    logic          TX_BUSY = 1'b0;
    logic          CMD_ERR, CTRL_BUSY;

    reg_file_cmd_ctrl #(.ADDR_WIDTH(AW), .REG_WIDTH(16), .WR_CMD(8'hAA),
                        .RD_CMD(8'hBB), .TIMEOUT_CYCLES(10)) dut (
        .CLK(CLK), .RST(RST), .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
        .WrEn(WrEn), .RdEn(RdEn), .Address(Address), .WrData(WrData),
        .RdData(RdData), .TX_P_DATA(TX_P_DATA), .TX_D_VLD(TX_D_VLD),
        .TX_BUSY(TX_BUSY), .CMD_ERR(CMD_ERR), .CTRL_BUSY(CTRL_BUSY));

    always #5 CLK = ~CLK;

    int errors = 0, checks = 0;
    int cyc = 0, rx_cyc = 0;
    bit skip_err_lat = 1'b0;

    // Simple register file model: RdData is valid only in the cycle after RdEn.
    logic [15:0] mem [0:7] = '{default: 16'h0000};
    always @(posedge CLK) begin
        cyc    <= cyc + 1;
        RdData <= RdEn ? mem[Address] : 16'hDEAD;
        if (WrEn) mem[Address] <= WrData;
    end

    logic [18:0] exp_wr[$];   // {addr, data}
    logic [2:0]  exp_rd[$];
    logic [7:0]  exp_tx[$];
    int          exp_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor
    logic        pv = 1'b0, pb = 1'b0;
    logic [7:0]  pd = 8'h00;
    logic [18:0] e_wr;
    logic [2:0]  e_rd;
    logic [7:0]  e_tx;
    always @(negedge CLK) begin
        if (!RST) begin
            if (WrEn) begin
                if (exp_wr.size() == 0) chk("wr_unexpected", 1, 0);
                else begin
                    e_wr = exp_wr.pop_front();
                    chk("wr_addr", Address, e_wr[18:16]);
                    chk("wr_data", WrData, e_wr[15:0]);
                    chk("wr_latency", cyc - rx_cyc, 1);
                end
            end
            if (RdEn) begin
                if (exp_rd.size() == 0) chk("rd_unexpected", 1, 0);
                else begin
                    e_rd = exp_rd.pop_front();
                    chk("rd_addr", Address, e_rd);
                    chk("rd_latency", cyc - rx_cyc, 1);
                end
            end
            if (CMD_ERR) begin
                chk("err_expected", exp_err > 0, 1);
                if (exp_err > 0) exp_err--;
                if (!skip_err_lat) chk("err_latency", cyc - rx_cyc, 1);
            end
            if (TX_D_VLD && !pv) chk("tx_vld_latency", cyc - rx_cyc, 3);
            if (pv && pb) begin
                chk("tx_vld_hold", TX_D_VLD, 1);
                chk("tx_data_hold", TX_P_DATA, pd);
            end
            if (TX_D_VLD && !TX_BUSY) begin
                if (exp_tx.size() == 0) chk("tx_unexpected", 1, 0);
                else begin
                    e_tx = exp_tx.pop_front();
                    chk("tx_byte", TX_P_DATA, e_tx);
                end
            end
        end
        pv = TX_D_VLD && !RST;
        pb = TX_BUSY;
        pd = TX_P_DATA;
    end

    task automatic send(input logic [7:0] b);
        @(posedge CLK); #1;
        RX_P_DATA = b;  RX_D_VLD = 1'b1;  rx_cyc = cyc;
        @(posedge CLK); #1;
        RX_D_VLD = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 100; i++) begin
            @(posedge CLK); #1;
            if (!CTRL_BUSY) break;
        end
        chk("idle_reached", CTRL_BUSY, 0);
    endtask

    task automatic do_write(input logic [2:0] a, input logic [15:0] d);
        exp_wr.push_back({a, d});
        send(8'hAA); send({5'b0, a}); send(d[7:0]); send(d[15:8]);
        wait_idle();
    endtask

    task automatic do_read(input logic [2:0] a, input logic [7:0] lo, input logic [7:0] hi);
        exp_rd.push_back(a);
        exp_tx.push_back(lo);  exp_tx.push_back(hi);
        send(8'hBB); send({5'b0, a});
        wait_idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected end of test");
        $fatal(1);
    end

    initial begin
        // Reset for two cycles, then every output must be zero.
        RST = 1'b1;
        repeat (2) @(posedge CLK);
        #1 RST = 1'b0;
        chk("rst_wren", WrEn, 0);
        chk("rst_rden", RdEn, 0);
        chk("rst_addr", Address, 0);
        chk("rst_wrdata", WrData, 0);
        chk("rst_txdata", TX_P_DATA, 0);
        chk("rst_txvld", TX_D_VLD, 0);
        chk("rst_err", CMD_ERR, 0);
        chk("rst_busy", CTRL_BUSY, 0);

        // Writes: basic, top address, opcode values used as data.
        do_write(3'd1, 16'h000F);
        do_write(3'd7, 16'h1234);
        do_write(3'd0, 16'hBBAA);

        // Read-back with the transmitter busy. A stray byte during TX_LO is
        // dropped with an error, and the held byte must stay stable.
        TX_BUSY = 1'b1;
        exp_rd.push_back(3'd1);
        exp_tx.push_back(8'h0F);  exp_tx.push_back(8'h00);
        send(8'hBB); send(8'h01);
        repeat (7) @(posedge CLK);
        exp_err++;
        send(8'h55);
        TX_BUSY = 1'b0;
        wait_idle();

        do_read(3'd7, 8'h34, 8'h12);
        do_read(3'd0, 8'hAA, 8'hBB);

        // Bad address, then both following bytes are unknown opcodes in IDLE.
        exp_err += 3;
        send(8'hAA); send(8'h14); send(8'h64); send(8'h00);
        wait_idle();

        // First out-of-range address on a read.
        exp_err++;
        send(8'hBB); send(8'h08);
        wait_idle();

        // Reset mid-frame discards the partial write.
        send(8'hAA); send(8'h03);
        @(posedge CLK); #1 RST = 1'b1;
        @(posedge CLK); #1 RST = 1'b0;
        chk("midrst_busy", CTRL_BUSY, 0);
        chk("midrst_addr", Address, 0);
        do_read(3'd3, 8'h00, 8'h00);

`ifdef CMD_TIMEOUT_EN
        // A partial frame times out after 10 silent cycles.
        skip_err_lat = 1'b1;
        exp_err++;
        send(8'hAA); send(8'h02);
        repeat (15) @(posedge CLK);
        #1 chk("tmo_busy", CTRL_BUSY, 0);
        skip_err_lat = 1'b0;
`endif

        repeat (5) @(posedge CLK);
        #1;
        chk("left_wr", exp_wr.size(), 0);
        chk("left_rd", exp_rd.size(), 0);
        chk("left_tx", exp_tx.size(), 0);
        chk("left_err", exp_err, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
